sram_port_arbiter: RTL and testbench

- Shares one single-ported synchronous SRAM between the IF fetch requester and the EX/MEM data requester.
- Sits between the pipeline stages and the SRAM. Grants at most one access per cycle and routes the read data back to the requester that issued it.
- Raises a stall request to the stall controller whenever a requester is held off.
- Data has priority over fetch. A starvation counter guarantees fetch progress.

---
 rtl/sram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-ported synchronous SRAM between the IF fetch
//            requester and the EX/MEM data requester. At most one access is
//            granted per cycle. Data has priority over fetch, but a run
//            counter caps consecutive data grants while a fetch waits. Read
//            data (or a write ack) returns exactly one cycle after the grant
//            and is routed to the requester that issued the access.
// Ports    : clk, rst (async, active-low)
//            inst_*  : fetch request/grant/response
//            data_*  : data request/grant/response (data_wen==0 is a read)
//            sram_*  : SRAM port, driven combinationally from the winner
//            stall_req : a requester is held off this cycle
// Options  : `define ARB_PERF_CNT_EN adds saturating perf_inst_wait and
//            perf_data_acc counters (and their output ports).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_inst_wait,
    output logic [31:0]       perf_data_acc,
`endif
    output logic              stall_req
);

    localparam logic [3:0] C_MAX_RUN = 4'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_I    = 2'd1,
        RESP_D_RD = 2'd2,
        RESP_D_WR = 2'd3
    } resp_state_t;

    resp_state_t r_resp_state;
    resp_state_t w_resp_state_nxt;
    logic [3:0]  r_run_cnt;
    logic [3:0]  w_run_cnt_nxt;
    logic        w_inst_gnt;
    logic        w_data_gnt;

    // ------------------------------------------------------------------------
    // Grant decision. Data wins unless a fetch has waited through
    // MAX_DATA_RUN consecutive data grants. Grants are qualified with rst so
    // that every output, including the combinational SRAM port, is quiet
    // while reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_data_gnt = rst & data_req & (~inst_req | (r_run_cnt < C_MAX_RUN));
        w_inst_gnt = rst & inst_req & ~w_data_gnt;
    end

    assign inst_gnt  = w_inst_gnt;
    assign data_gnt  = w_data_gnt;
    assign stall_req = rst & ((inst_req & ~w_inst_gnt) | (data_req & ~w_data_gnt));

    // SRAM port follows the granted requester.
    always_comb begin
        sram_en    = w_inst_gnt | w_data_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_data_gnt) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (w_inst_gnt) begin
            sram_addr  = inst_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: the response due next cycle is set by this cycle's grant;
    // the run counter only accumulates while a fetch is actually waiting.
    // ------------------------------------------------------------------------
    always_comb begin
        w_resp_state_nxt = IDLE;
        w_run_cnt_nxt    = r_run_cnt;

        if (w_data_gnt) begin
            w_resp_state_nxt = (data_wen != 4'b0000) ? RESP_D_WR : RESP_D_RD;
        end else if (w_inst_gnt) begin
            w_resp_state_nxt = RESP_I;
        end

        if (!inst_req || w_inst_gnt) begin
            w_run_cnt_nxt = 4'd0;
        end else if (w_data_gnt && (r_run_cnt < C_MAX_RUN)) begin
            w_run_cnt_nxt = r_run_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_state <= IDLE;
            r_run_cnt    <= 4'd0;
        end else begin
            r_resp_state <= w_resp_state_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Response routing. Write acks carry zero data.
    // ------------------------------------------------------------------------
    always_comb begin
        inst_rvalid = (r_resp_state == RESP_I);
        inst_rdata  = (r_resp_state == RESP_I) ? sram_rdata : '0;
        data_rvalid = (r_resp_state == RESP_D_RD) || (r_resp_state == RESP_D_WR);
        data_rdata  = (r_resp_state == RESP_D_RD) ? sram_rdata : '0;
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_inst_wait;
    logic [31:0] r_perf_data_acc;
    logic        w_inst_wait;

    assign w_inst_wait = inst_req & ~w_inst_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_inst_wait <= 32'd0;
            r_perf_data_acc  <= 32'd0;
        end else begin
            if (w_inst_wait && (r_perf_inst_wait != 32'hFFFF_FFFF)) begin
                r_perf_inst_wait <= r_perf_inst_wait + 32'd1;
            end
            if (w_data_gnt && (r_perf_data_acc != 32'hFFFF_FFFF)) begin
                r_perf_data_acc <= r_perf_data_acc + 32'd1;
            end
        end
    end

    assign perf_inst_wait = r_perf_inst_wait;
    assign perf_data_acc  = r_perf_data_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed self-checking bench for sram_port_arbiter with a small
//            write-first SRAM model. Build with ARB_PERF_CNT_EN defined to
//            also check the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall_req;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_wait;
    logic [31:0] perf_data_acc;
`endif

    int n_cmp;
    int n_err;

    sram_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_DATA_RUN (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
`ifdef ARB_PERF_CNT_EN
        .perf_inst_wait (perf_inst_wait),
        .perf_data_acc  (perf_data_acc),
`endif
        .stall_req   (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // SRAM model: 256 words indexed by addr[9:2]. Unwritten words read back
    // as 0xA5000000 | addr[15:0]. Write-first. ovr_en substitutes ovr_data
    // for the read result so a fixed address can return a chosen sequence.
    // ------------------------------------------------------------------------
    logic [31:0]  mem [0:255];
    logic [255:0] written;
    logic         ovr_en;
    logic [31:0]  ovr_data;

    function automatic logic [31:0] merged(input logic [31:0] addr, input logic [3:0] wen,
                                           input logic [31:0] wdata, input logic [31:0] old,
                                           input logic was_written);
        logic [31:0] v;
        v = was_written ? old : (32'hA500_0000 | {16'h0, addr[15:0]});
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) v[8*b +: 8] = wdata[8*b +: 8];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            written    <= '0;
            sram_rdata <= 32'd0;
        end else if (sram_en) begin
            if (ovr_en) begin
                sram_rdata <= ovr_data;
            end else begin
                sram_rdata <= merged(sram_addr, sram_wen, sram_wdata,
                                     mem[sram_addr[9:2]], written[sram_addr[9:2]]);
            end
            if (sram_wen != 4'b0000) begin
                mem[sram_addr[9:2]]     <= merged(sram_addr, sram_wen, sram_wdata,
                                                  mem[sram_addr[9:2]], written[sram_addr[9:2]]);
                written[sram_addr[9:2]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; checks happen at the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_wen   = 4'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        ovr_en     = 1'b0;
        ovr_data   = 32'd0;

        // ---- reset state, with both requests raised to expose any leak ----
        repeat (2) @(negedge clk);
        inst_req  = 1'b1;
        data_req  = 1'b1;
        inst_addr = 32'h40;
        data_addr = 32'h100;
        #1;
        chk("rst_inst_gnt",  {63'd0, inst_gnt},  64'd0);
        chk("rst_data_gnt",  {63'd0, data_gnt},  64'd0);
        chk("rst_sram_en",   {63'd0, sram_en},   64'd0);
        chk("rst_sram_addr", {32'd0, sram_addr}, 64'd0);
        chk("rst_stall",     {63'd0, stall_req}, 64'd0);
        chk("rst_rvalid",    {62'd0, inst_rvalid, data_rvalid}, 64'd0);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // ---- fetch only: same address, SRAM returns 0x11/0x22/0x33 ----
        to_drive();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        ovr_en    = 1'b1;
        ovr_data  = 32'h11;
        to_check();
        chk("f0_gnt",    {63'd0, inst_gnt},    64'd1);
        chk("f0_stall",  {63'd0, stall_req},   64'd0);
        chk("f0_addr",   {32'd0, sram_addr},   64'hBFC0_0000);
        chk("f0_rvalid", {63'd0, inst_rvalid}, 64'd0);
        to_drive();
        ovr_data = 32'h22;
        to_check();
        chk("f1_gnt",    {63'd0, inst_gnt},    64'd1);
        chk("f1_rvalid", {63'd0, inst_rvalid}, 64'd1);
        chk("f1_rdata",  {32'd0, inst_rdata},  64'h11);
        to_drive();
        ovr_data = 32'h33;
        to_check();
        chk("f2_gnt",    {63'd0, inst_gnt},    64'd1);
        chk("f2_rdata",  {32'd0, inst_rdata},  64'h22);
        chk("f2_stall",  {63'd0, stall_req},   64'd0);
        to_drive();
        inst_req = 1'b0;
        ovr_en   = 1'b0;
        to_check();
        chk("f3_rvalid", {63'd0, inst_rvalid}, 64'd1);
        chk("f3_rdata",  {32'd0, inst_rdata},  64'h33);
        chk("f3_sram_en",{63'd0, sram_en},     64'd0);
        to_drive();
        to_check();
        chk("f4_rvalid", {63'd0, inst_rvalid}, 64'd0);
        chk("f4_rdata",  {32'd0, inst_rdata},  64'd0);

        // ---- conflict: data read wins, fetch follows next cycle ----
        to_drive();
        inst_req  = 1'b1;
        inst_addr = 32'h40;
        data_req  = 1'b1;
        data_wen  = 4'd0;
        data_addr = 32'h100;
        to_check();
        chk("c0_data_gnt", {63'd0, data_gnt},  64'd1);
        chk("c0_inst_gnt", {63'd0, inst_gnt},  64'd0);
        chk("c0_stall",    {63'd0, stall_req}, 64'd1);
        chk("c0_addr",     {32'd0, sram_addr}, 64'h100);
        to_drive();
        data_req = 1'b0;
        to_check();
        chk("c1_inst_gnt", {63'd0, inst_gnt},    64'd1);
        chk("c1_d_rvalid", {63'd0, data_rvalid}, 64'd1);
        chk("c1_d_rdata",  {32'd0, data_rdata},  64'hA500_0100);
        chk("c1_stall",    {63'd0, stall_req},   64'd0);
        chk("c1_addr",     {32'd0, sram_addr},   64'h40);
        to_drive();
        inst_req = 1'b0;
        to_check();
        chk("c2_i_rvalid", {63'd0, inst_rvalid}, 64'd1);
        chk("c2_i_rdata",  {32'd0, inst_rdata},  64'hA500_0040);
        chk("c2_d_rvalid", {63'd0, data_rvalid}, 64'd0);

        // ---- write ack then readback of the same word ----
        to_drive();
        data_req   = 1'b1;
        data_wen   = 4'hF;
        data_addr  = 32'h200;
        data_wdata = 32'hDEAD_BEEF;
        to_check();
        chk("w0_gnt",   {63'd0, data_gnt},    64'd1);
        chk("w0_wen",   {60'd0, sram_wen},    64'hF);
        chk("w0_wdata", {32'd0, sram_wdata},  64'hDEAD_BEEF);
        to_drive();
        data_wen   = 4'h0;
        data_wdata = 32'd0;
        to_check();
        chk("w1_wen",    {60'd0, sram_wen},    64'h0);
        chk("w1_rvalid", {63'd0, data_rvalid}, 64'd1);
        chk("w1_rdata",  {32'd0, data_rdata},  64'd0);
        to_drive();
        data_req = 1'b0;
        to_check();
        chk("w2_rvalid", {63'd0, data_rvalid}, 64'd1);
        chk("w2_rdata",  {32'd0, data_rdata},  64'hDEAD_BEEF);

        // ---- asynchronous reset while a fetch response is in flight ----
        to_drive();
        inst_req  = 1'b1;
        inst_addr = 32'h40;
        to_check();
        chk("r0_gnt", {63'd0, inst_gnt}, 64'd1);
        to_drive();
        data_req  = 1'b1;
        data_addr = 32'h100;
        #2;
        chk("r1_pre_rvalid", {63'd0, inst_rvalid}, 64'd1);
        chk("r1_pre_stall",  {63'd0, stall_req},   64'd1);
        rst = 1'b0;
        #1;
        chk("r1_rvalid",  {63'd0, inst_rvalid}, 64'd0);
        chk("r1_rdata",   {32'd0, inst_rdata},  64'd0);
        chk("r1_gnt",     {62'd0, inst_gnt, data_gnt}, 64'd0);
        chk("r1_sram_en", {63'd0, sram_en},     64'd0);
        chk("r1_stall",   {63'd0, stall_req},   64'd0);
        chk("r1_d_rvalid",{63'd0, data_rvalid}, 64'd0);
        to_drive();
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("r2_rvalid", {62'd0, inst_rvalid, data_rvalid}, 64'd0);
        to_drive();
        to_check();
        chk("r3_rvalid", {62'd0, inst_rvalid, data_rvalid}, 64'd0);

        // ---- starvation bound: expect D,D,D,D,I,D,D,D,D,I ----
        for (int i = 0; i < 10; i++) begin
            to_drive();
            inst_req  = 1'b1;
            inst_addr = 32'h40;
            data_req  = 1'b1;
            data_wen  = 4'd0;
            data_addr = 32'h100;
            to_check();
            chk($sformatf("s%0d_data_gnt", i), {63'd0, data_gnt}, (i % 5 != 4) ? 64'd1 : 64'd0);
            chk($sformatf("s%0d_inst_gnt", i), {63'd0, inst_gnt}, (i % 5 == 4) ? 64'd1 : 64'd0);
        end
        to_drive();
        inst_req = 1'b0;
        data_req = 1'b0;
        to_check();
        chk("s_end_i_rvalid", {63'd0, inst_rvalid}, 64'd1);
`ifdef ARB_PERF_CNT_EN
        chk("perf_data_acc",  {32'd0, perf_data_acc},  64'd8);
        chk("perf_inst_wait", {32'd0, perf_inst_wait}, 64'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
